// File: rtl/veldt_rvfi_packer_pkg.sv
// Shared types and constants for the Veldt RVFI retirement packer.
// The packet struct is used for both the collection shadow and the output register.
package veldt_rvfi_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned ILEN_DEF    = 32;
    localparam int unsigned ORDER_W_DEF = 64;
    localparam int unsigned MASK_W_DEF  = XLEN_DEF / 8;

    localparam logic [1:0] RVFI_MODE_M = 2'b11;
    localparam logic [1:0] RVFI_IXL_32 = 2'b01;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    typedef struct packed {
        logic [ORDER_W_DEF-1:0] order;
        logic [ILEN_DEF-1:0]    insn;
        logic                   trap;
        logic                   halt;
        logic                   intr;
        logic [1:0]             mode;
        logic [1:0]             ixl;
        logic [4:0]             rs1_addr;
        logic [4:0]             rs2_addr;
        logic [4:0]             rd_addr;
        logic [XLEN_DEF-1:0]    rs1_rdata;
        logic [XLEN_DEF-1:0]    rs2_rdata;
        logic [XLEN_DEF-1:0]    rd_wdata;
        logic [XLEN_DEF-1:0]    pc_rdata;
        logic [XLEN_DEF-1:0]    pc_wdata;
        logic [XLEN_DEF-1:0]    mem_addr;
        logic [MASK_W_DEF-1:0]  mem_rmask;
        logic [MASK_W_DEF-1:0]  mem_wmask;
        logic [XLEN_DEF-1:0]    mem_rdata;
        logic [XLEN_DEF-1:0]    mem_wdata;
    } rvfi_pkt_t;

    // A freshly fetched instruction: only pc/insn known, every event field cleared.
    function automatic rvfi_pkt_t new_insn(input logic [XLEN_DEF-1:0] pc,
                                           input logic [ILEN_DEF-1:0] insn);
        rvfi_pkt_t p;
        p          = '0;
        p.pc_rdata = pc;
        p.insn     = insn;
        return p;
    endfunction

endpackage

// File: rtl/veldt_rvfi_packer_if.sv
// Core-side event bus feeding the RVFI packer: fetch, register read,
// memory access, writeback and commit facts.
interface veldt_rvfi_packer_if #(
    parameter int unsigned XLEN = veldt_rvfi_pkg::XLEN_DEF,
    parameter int unsigned ILEN = veldt_rvfi_pkg::ILEN_DEF
) ();

    logic              fetch_valid;
    logic [XLEN-1:0]   fetch_pc;
    logic [ILEN-1:0]   fetch_insn;
    logic              rs_valid;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [XLEN-1:0]   rs1_rdata;
    logic [XLEN-1:0]   rs2_rdata;
    logic              mem_valid;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_rmask;
    logic [XLEN/8-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              wb_valid;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              commit_valid;
    logic              commit_trap;
    logic [XLEN-1:0]   commit_next_pc;

    modport master (
        output fetch_valid, fetch_pc, fetch_insn,
        output rs_valid, rs1_addr, rs2_addr, rs1_rdata, rs2_rdata,
        output mem_valid, mem_addr, mem_rmask, mem_wmask, mem_wdata, mem_rdata,
        output wb_valid, wb_addr, wb_data,
        output commit_valid, commit_trap, commit_next_pc
    );

    modport slave (
        input fetch_valid, fetch_pc, fetch_insn,
        input rs_valid, rs1_addr, rs2_addr, rs1_rdata, rs2_rdata,
        input mem_valid, mem_addr, mem_rmask, mem_wmask, mem_wdata, mem_rdata,
        input wb_valid, wb_addr, wb_data,
        input commit_valid, commit_trap, commit_next_pc
    );

endinterface

// File: rtl/veldt_rvfi_packer.sv
// Collects per-instruction events from the multi-cycle Veldt core and emits one
// registered RVFI retirement packet per commit; flags core protocol violations.
module veldt_rvfi_packer
    import veldt_rvfi_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned ILEN    = ILEN_DEF,
    parameter int unsigned ORDER_W = ORDER_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    veldt_rvfi_packer_if.slave core,
    output logic               rvfi_valid,
    output logic [ORDER_W-1:0] rvfi_order,
    output logic [ILEN-1:0]    rvfi_insn,
    output logic               rvfi_trap,
    output logic               rvfi_halt,
    output logic               rvfi_intr,
    output logic [1:0]         rvfi_mode,
    output logic [1:0]         rvfi_ixl,
    output logic [4:0]         rvfi_rs1_addr,
    output logic [4:0]         rvfi_rs2_addr,
    output logic [4:0]         rvfi_rd_addr,
    output logic [XLEN-1:0]    rvfi_rs1_rdata,
    output logic [XLEN-1:0]    rvfi_rs2_rdata,
    output logic [XLEN-1:0]    rvfi_rd_wdata,
    output logic [XLEN-1:0]    rvfi_pc_rdata,
    output logic [XLEN-1:0]    rvfi_pc_wdata,
    output logic [XLEN-1:0]    rvfi_mem_addr,
    output logic [XLEN/8-1:0]  rvfi_mem_rmask,
    output logic [XLEN/8-1:0]  rvfi_mem_wmask,
    output logic [XLEN-1:0]    rvfi_mem_rdata,
    output logic [XLEN-1:0]    rvfi_mem_wdata,
    output logic               protocol_err
);

    state_t             state_q, state_d;
    rvfi_pkt_t          shadow_q, shadow_d, cur, fresh, pkt_d, out_q;
    logic [ORDER_W-1:0] order_q;
    logic               valid_q, err_q, emit, err_set;

    // Shadow merged with this cycle's events, so same-cycle events reach a commit.
    always_comb begin
        cur = shadow_q;
        if (core.rs_valid) begin
            cur.rs1_addr  = core.rs1_addr;
            cur.rs2_addr  = core.rs2_addr;
            cur.rs1_rdata = core.rs1_rdata;
            cur.rs2_rdata = core.rs2_rdata;
        end
        if (core.mem_valid) begin
            cur.mem_addr  = core.mem_addr;
            cur.mem_rmask = core.mem_rmask;
            cur.mem_wmask = core.mem_wmask;
            cur.mem_rdata = core.mem_rdata;
            cur.mem_wdata = core.mem_wdata;
        end
        if (core.wb_valid) begin
            cur.rd_addr  = core.wb_addr;
            cur.rd_wdata = core.wb_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        pkt_d    = out_q;
        emit     = 1'b0;
        err_set  = 1'b0;
        fresh    = new_insn(core.fetch_pc, core.fetch_insn);
        case (state_q)
            IDLE: begin
                if (core.commit_valid) err_set = 1'b1;
                if (core.fetch_valid) begin
                    shadow_d = fresh;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                shadow_d = cur;
                if (core.commit_valid) begin
                    emit           = 1'b1;
                    pkt_d          = cur;
                    pkt_d.order    = order_q;
                    pkt_d.trap     = core.commit_trap;
                    pkt_d.halt     = 1'b0;
                    pkt_d.intr     = 1'b0;
                    pkt_d.mode     = RVFI_MODE_M;
                    pkt_d.ixl      = RVFI_IXL_32;
                    pkt_d.pc_wdata = core.commit_next_pc;
                    if (cur.rd_addr == 5'd0) pkt_d.rd_wdata = '0;
                    if (core.commit_trap) begin
                        pkt_d.rd_addr   = '0;
                        pkt_d.rd_wdata  = '0;
                        pkt_d.mem_rmask = '0;
                        pkt_d.mem_wmask = '0;
                    end
                    if (core.fetch_valid) shadow_d = fresh;
                    else                  state_d  = IDLE;
                end else if (core.fetch_valid) begin
                    err_set  = 1'b1;
                    shadow_d = fresh;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            order_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            out_q    <= pkt_d;
            valid_q  <= emit;
            if (emit)    order_q <= order_q + 1'b1;
            if (err_set) err_q   <= 1'b1;
        end
    end

    assign rvfi_valid     = valid_q;
    assign rvfi_order     = out_q.order;
    assign rvfi_insn      = out_q.insn;
    assign rvfi_trap      = out_q.trap;
    assign rvfi_halt      = out_q.halt;
    assign rvfi_intr      = out_q.intr;
    assign rvfi_mode      = out_q.mode;
    assign rvfi_ixl       = out_q.ixl;
    assign rvfi_rs1_addr  = out_q.rs1_addr;
    assign rvfi_rs2_addr  = out_q.rs2_addr;
    assign rvfi_rd_addr   = out_q.rd_addr;
    assign rvfi_rs1_rdata = out_q.rs1_rdata;
    assign rvfi_rs2_rdata = out_q.rs2_rdata;
    assign rvfi_rd_wdata  = out_q.rd_wdata;
    assign rvfi_pc_rdata  = out_q.pc_rdata;
    assign rvfi_pc_wdata  = out_q.pc_wdata;
    assign rvfi_mem_addr  = out_q.mem_addr;
    assign rvfi_mem_rmask = out_q.mem_rmask;
    assign rvfi_mem_wmask = out_q.mem_wmask;
    assign rvfi_mem_rdata = out_q.mem_rdata;
    assign rvfi_mem_wdata = out_q.mem_wdata;
    assign protocol_err   = err_q;

endmodule

// File: doc/veldt_rvfi_packer.md
Name: veldt_rvfi_packer

Overview:
- Sits inside VeldtFV, directly upstream of the formal RVFI interface consumed by the riscv-formal harness.
- Veldt is a multi-cycle, non-pipelined core. Its FSM produces per-instruction facts (fetch, register read, memory access, writeback, commit) in different cycles.
- This block collects those events for one instruction and emits a single-cycle RVFI retirement packet with a monotonically increasing order number.
- It also flags core-side protocol violations.

Parameters:
- XLEN, 32, data/address width
- ILEN, 32, instruction width
- ORDER_W, 64, rvfi_order width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- fetch_valid  in  1  instruction fetched this cycle
- fetch_pc  in  XLEN  PC of fetched instruction
- fetch_insn  in  ILEN  fetched instruction word
- rs_valid  in  1  register-file read event
- rs1_addr, rs2_addr  in  5 each  source register indices
- rs1_rdata, rs2_rdata  in  XLEN each  source operand values
- mem_valid  in  1  data-memory access event
- mem_addr  in  XLEN  access address
- mem_rmask, mem_wmask  in  XLEN/8 each  byte read/write masks
- mem_wdata, mem_rdata  in  XLEN each  store data / load data
- wb_valid  in  1  register writeback event
- wb_addr  in  5  destination register index
- wb_data  in  XLEN  writeback value
- commit_valid  in  1  instruction retires this cycle
- commit_trap  in  1  retiring instruction trapped
- commit_next_pc  in  XLEN  PC of next instruction
- rvfi_valid  out  1  packet valid, one-cycle pulse
- rvfi_order  out  ORDER_W  retirement index
- rvfi_insn  out  ILEN  retired instruction word
- rvfi_trap, rvfi_halt, rvfi_intr  out  1 each  retirement flags
- rvfi_mode, rvfi_ixl  out  2 each  privilege mode / XLEN encoding
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  out  5 each  register indices
- rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  out  XLEN each  register values
- rvfi_pc_rdata, rvfi_pc_wdata  out  XLEN each  current / next PC
- rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata  out  per RVFI  memory fields
- protocol_err  out  1  sticky core-protocol violation flag

Behaviour:
- Reset:
  - Takes effect on the clk edge while reset=0; dominates all inputs.
  - Forces state IDLE, order counter 0, protocol_err 0, and every rvfi_* output 0.
  - An in-flight instruction is dropped and produces no packet.
- States: IDLE, COLLECT.
- IDLE:
  - fetch_valid: capture pc/insn, clear rs/mem/wb shadow fields and their seen bits, go to COLLECT.
  - commit_valid: set protocol_err, emit no packet.
- COLLECT:
  - rs_valid, mem_valid, wb_valid each capture their fields and set their seen bit. A repeated event overwrites (last wins).
  - Events asserted in the same cycle as commit_valid are included in the packet (bypass).
- Commit in COLLECT:
  - rvfi_valid=1 on the next cycle, for exactly one cycle; all packet fields are registered.
  - Latency from commit to rvfi_valid is 1 cycle.
- Back-to-back: fetch_valid together with commit_valid retires the old instruction and captures the new one; state stays COLLECT.
- fetch_valid in COLLECT without commit_valid: set protocol_err, discard the old instruction (no packet), capture the new one.
- Field rules:
  - Unseen rs fields: addr/rdata 0. Unseen mem fields: all 0. Unseen wb: rd_addr 0, rd_wdata 0.
  - wb_addr==0 forces rd_wdata 0.
  - commit_trap=1: rvfi_trap=1; rd_addr, rd_wdata and both mem masks forced 0; pc_wdata=commit_next_pc.
  - Constants: rvfi_halt=0, rvfi_intr=0, rvfi_mode=2'b11, rvfi_ixl=2'b01.
- Order counter:
  - First packet after reset carries order 0.
  - Increments by 1 after each emitted packet; wraps modulo 2^ORDER_W.
  - Discarded instructions do not consume an order number.
- When rvfi_valid=0, rvfi_* hold the last packet; rvfi_valid itself is 0.
- protocol_err is cleared only by reset.

Decomposition:
- Package veldt_rvfi_pkg holds:
  - XLEN/ILEN defaults
  - state enum (IDLE, COLLECT)
  - rvfi_pkt_t struct of all packet fields
  - constants RVFI_MODE_M=2'b11, RVFI_IXL_32=2'b01
- Single module; no sub-module is natural. The shadow register set and the output register are both rvfi_pkt_t.

Test Plan:
- ADDI x1,x0,5 (insn 0x00500093, pc 0x0): fetch, rs(x0=0), wb(x1=5), commit next_pc 0x4 -> one pulse: order 0, rd_addr 1, rd_wdata 5, pc_wdata 0x4, masks 0.
- LW x2,0(x1) at pc 0x4: mem addr 0x5, rmask 0xF, rdata 0xDEADBEEF, wb x2 -> order 1, mem_rmask 0xF, rd_wdata 0xDEADBEEF.
- Writeback to x0 with data 0x1234 -> rd_addr 0, rd_wdata 0.
- commit_trap=1 with a prior wb (x3=7) and mem wmask 0xF -> rvfi_trap 1, rd_addr 0, rd_wdata 0, wmask 0.
- Protocol errors:
  - Commit while IDLE -> no rvfi_valid, protocol_err=1.
  - Two fetches without commit -> only the second instruction retires, order not skipped.
- Reset mid-instruction:
  - reset=0 asserted after fetch and wb, before commit -> no packet, all outputs 0.
  - Next retirement after reset release has order 0.
